nes_oam_dma: RTL

Sprite DMA engine for the NES core, sitting directly downstream of the 6502 CPU on the data bus. It watches CPU writes (`EA`/`DOUT`/`WREQ`). A write to `$4014` freezes the CPU through `CE`, takes over the memory address bus, and copies 256 bytes from CPU page `$XX00–$XXFF` into PPU sprite memory (OAM), starting at the current OAM base address.

---
 rtl/nes_oam_dma.sv | 104 ++++++++++
 1 files changed

// File: rtl/nes_oam_dma.sv
// rtl/nes_oam_dma.sv - 256-byte sprite DMA from a CPU page into PPU OAM; define OAM_DMA_ODD_ALIGN_EN for 2A03 parity alignment
module nes_oam_dma #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] CPU_EA,
    input  logic [7:0]  CPU_DOUT,
    input  logic        CPU_WREQ,
    output logic        CE,
    output logic        DMA_ACT,
    output logic [15:0] MEM_ADDR,
    input  logic [7:0]  MEM_DIN,
    input  logic [7:0]  OAM_BASE,
    output logic [7:0]  OAM_ADDR,
    output logic [7:0]  OAM_DATA,
    output logic        OAM_WE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state;
    logic        wreq_q;
    logic [7:0]  page;
    logic [7:0]  cnt;
    logic        trig;
`ifdef OAM_DMA_ODD_ALIGN_EN
    logic        par;
`endif

    assign trig = CPU_WREQ && !wreq_q && (CPU_EA == TRIG_ADDR);

    // Bus control is decoded straight from the state register so the CPU
    // stall and address mux never see a path from memory data.
    assign CE       = (state == S_IDLE);
    assign DMA_ACT  = (state != S_IDLE);
    assign MEM_ADDR = DMA_ACT ? {page, cnt} : 16'h0000;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            wreq_q   <= 1'b0;
            page     <= 8'h00;
            cnt      <= 8'h00;
            OAM_ADDR <= 8'h00;
            OAM_DATA <= 8'h00;
            OAM_WE   <= 1'b0;
`ifdef OAM_DMA_ODD_ALIGN_EN
            par      <= 1'b0;
`endif
        end else begin
            wreq_q <= CPU_WREQ;
            OAM_WE <= 1'b0;
`ifdef OAM_DMA_ODD_ALIGN_EN
            par    <= ~par;
`endif
            // The strobe cycle uses the current OAM_ADDR; advance right after it.
            if (OAM_WE) begin
                OAM_ADDR <= OAM_ADDR + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (trig) begin
                        page     <= CPU_DOUT;
                        OAM_ADDR <= OAM_BASE;
                        cnt      <= 8'h00;
                        state    <= S_HALT;
                    end
                end
                S_HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                    state <= par ? S_ALIGN : S_READ;
`else
                    state <= S_READ;
`endif
                end
`ifdef OAM_DMA_ODD_ALIGN_EN
                S_ALIGN: begin
                    state <= S_READ;
                end
`endif
                S_READ: begin
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    OAM_DATA <= MEM_DIN;
                    OAM_WE   <= 1'b1;
                    cnt      <= cnt + 8'd1;
                    state    <= (cnt == 8'hFF) ? S_IDLE : S_READ;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
